// File: rtl/ide_sector_ctl.sv
// ide_sector_ctl: single-sector (512-byte) ATA PIO READ/WRITE SECTORS sequencer, LBA28 mode.
// Issues one taskfile access at a time to the IDE register engine and moves 256 16-bit words
// between the drive data register and a local sector buffer.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   cmd_read/write    single-cycle requests (read wins if both), lba sampled on accept
//   busy, done, err   busy from accept to done; done one-cycle pulse; err sticky until next accept
//   status            last status register value read
//   buf_*             local sector buffer port (buf_rdata valid one cycle after buf_addr changes)
//   ata_*             IDE engine request/response port; ata_addr = {cs[1:0], da[2:0]}
module ide_sector_ctl #(
   parameter int unsigned RECOVER    = 7,
   parameter int unsigned POLL_LIMIT = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_read,
   input  logic        cmd_write,
   input  logic [27:0] lba,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  status,
   output logic [7:0]  buf_addr,
   output logic [15:0] buf_wdata,
   output logic        buf_we,
   input  logic [15:0] buf_rdata,
   output logic        ata_rd,
   output logic        ata_wr,
   output logic [4:0]  ata_addr,
   output logic [15:0] ata_in,
   input  logic [15:0] ata_out,
   input  logic        ata_done
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_POLL_DRQ = 3'd2;
   localparam logic [2:0] S_XFER     = 3'd3;
   localparam logic [2:0] S_POLL_END = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_ERROR    = 3'd6;

   localparam logic [4:0] REG_DATA = 5'h10;
   localparam logic [4:0] REG_CMD  = 5'h17;

   logic [2:0]  state;
   logic [27:0] lba_q;
   logic        dir_wr;
   logic [2:0]  setup_idx;
   logic        pending;     // one engine access outstanding
   logic [15:0] rec_cnt;     // recovery idle cycles still to wait
   logic [15:0] poll_cnt;    // status reads so far in the current poll phase
   logic        adv;         // buf_addr steps in this cycle (after buf_we has been seen)
   logic        settle;      // buf_rdata still catching up with the new buf_addr

   logic        acc_phase;
   logic        acc_ready;
   logic        poll_expired;
   logic        nxt_wr;
   logic [4:0]  nxt_addr;
   logic [15:0] nxt_data;

   // Next engine access for the current phase.
   always_comb begin
      nxt_wr   = 1'b0;
      nxt_addr = REG_CMD;
      nxt_data = 16'h0000;
      case (state)
         S_SETUP: begin
            nxt_wr = 1'b1;
            case (setup_idx)
               3'd0:    begin nxt_addr = 5'h12; nxt_data = 16'h0001;                     end
               3'd1:    begin nxt_addr = 5'h13; nxt_data = {8'h00, lba_q[7:0]};          end
               3'd2:    begin nxt_addr = 5'h14; nxt_data = {8'h00, lba_q[15:8]};         end
               3'd3:    begin nxt_addr = 5'h15; nxt_data = {8'h00, lba_q[23:16]};        end
               3'd4:    begin nxt_addr = 5'h16; nxt_data = {8'h00, 4'hE, lba_q[27:24]};  end
               default: begin nxt_addr = REG_CMD; nxt_data = dir_wr ? 16'h0030 : 16'h0020; end
            endcase
         end
         S_XFER: begin
            nxt_wr   = dir_wr;
            nxt_addr = REG_DATA;
            nxt_data = buf_rdata;
         end
         default: ;
      endcase
   end

   assign acc_phase = (state == S_SETUP) || (state == S_POLL_DRQ) ||
                      (state == S_XFER)  || (state == S_POLL_END);
   assign acc_ready = acc_phase && !pending && (rec_cnt == 16'd0) && !adv && !settle;

   // True when the read completing now is the last one this poll phase may make.
   assign poll_expired = ({1'b0, poll_cnt} + 17'd1) >= 17'(POLL_LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         lba_q     <= '0;
         dir_wr    <= 1'b0;
         setup_idx <= '0;
         pending   <= 1'b0;
         rec_cnt   <= '0;
         poll_cnt  <= '0;
         adv       <= 1'b0;
         settle    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         status    <= 8'h00;
         buf_addr  <= '0;
         buf_wdata <= '0;
         buf_we    <= 1'b0;
         ata_rd    <= 1'b0;
         ata_wr    <= 1'b0;
         ata_addr  <= 5'h1F;
         ata_in    <= '0;
      end else begin
         ata_rd <= 1'b0;
         ata_wr <= 1'b0;
         done   <= 1'b0;
         buf_we <= 1'b0;
         adv    <= 1'b0;
         settle <= adv;

         // Wraps 255 -> 0 naturally at the end of the data phase.
         if (adv) buf_addr <= buf_addr + 8'd1;
         if (rec_cnt != 16'd0) rec_cnt <= rec_cnt - 16'd1;

         if (acc_ready) begin
            pending  <= 1'b1;
            ata_addr <= nxt_addr;
            ata_in   <= nxt_data;
            ata_wr   <= nxt_wr;
            ata_rd   <= !nxt_wr;
         end

         if (pending && ata_done) begin
            pending <= 1'b0;
            rec_cnt <= 16'(RECOVER);
            case (state)
               S_SETUP: begin
                  if (setup_idx == 3'd5) begin
                     state    <= S_POLL_DRQ;
                     poll_cnt <= '0;
                  end else begin
                     setup_idx <= setup_idx + 3'd1;
                  end
               end
               S_POLL_DRQ: begin
                  status <= ata_out[7:0];
                  // BSY masks every other bit; ERR outranks DRQ.
                  if (!ata_out[7] && ata_out[0])      state <= S_ERROR;
                  else if (!ata_out[7] && ata_out[3]) state <= S_XFER;
                  else if (poll_expired)              state <= S_ERROR;
                  else                                poll_cnt <= poll_cnt + 16'd1;
               end
               S_XFER: begin
                  adv <= 1'b1;
                  if (!dir_wr) begin
                     buf_we    <= 1'b1;
                     buf_wdata <= ata_out;
                  end
                  if (buf_addr == 8'hFF) begin
                     state    <= S_POLL_END;
                     poll_cnt <= '0;
                  end
               end
               S_POLL_END: begin
                  status <= ata_out[7:0];
                  if (!ata_out[7])       state <= ata_out[0] ? S_ERROR : S_DONE;
                  else if (poll_expired) state <= S_ERROR;
                  else                   poll_cnt <= poll_cnt + 16'd1;
               end
               default: ;
            endcase
         end

         case (state)
            S_IDLE: begin
               if (cmd_read || cmd_write) begin
                  lba_q     <= lba;
                  dir_wr    <= cmd_write && !cmd_read;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  setup_idx <= '0;
                  state     <= S_SETUP;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_ERROR: begin
               err   <= 1'b1;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ide_sector_ctl.md
Name: ide_sector_ctl

Overview:
- Sequences single-sector (512-byte) ATA PIO READ SECTORS (0x20) and WRITE SECTORS (0x30) transfers in LBA28 mode.
- Drives the existing IDE register-access engine: one taskfile register read or write per request.
- Moves 256 16-bit words between the drive and a local sector buffer.
- Sits between the disk/bus-interface logic (the requester) and the IDE engine.

Parameters:
- RECOVER, 7: idle cycles after ata_done before the next ata_rd/ata_wr pulse; covers engine return to its idle state.
- POLL_LIMIT, 65535: maximum status reads per poll phase before timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_read  in  1  single-cycle request: read sector at lba into the buffer
- cmd_write  in  1  single-cycle request: write the buffer to the sector at lba
- lba  in  28  sector address; sampled on command accept
- busy  out  1  high from command accept to done
- done  out  1  single-cycle completion pulse
- err  out  1  sticky error; cleared on next command accept
- status  out  8  last status register value read
- buf_addr  out  8  buffer word index
- buf_wdata  out  16  word read from the drive
- buf_we  out  1  buffer write strobe
- buf_rdata  in  16  buffer word; valid one cycle after buf_addr changes
- ata_rd  out  1  engine read request, one-cycle pulse
- ata_wr  out  1  engine write request, one-cycle pulse
- ata_addr  out  5  {cs[1:0], da[2:0]}
- ata_in  out  16  write data to the engine; valid in the ata_wr cycle
- ata_out  in  16  engine read data; valid from the ata_done cycle onward
- ata_done  in  1  engine cycle-complete pulse

Behaviour:
- Reset (async) values:
  - busy, done, err, buf_we, ata_rd, ata_wr = 0
  - status = 0x00
  - ata_addr = 5'h1F
  - ata_in, buf_addr, buf_wdata = 0
  - FSM = IDLE
- Reset mid-operation: abandons the transfer immediately; no done pulse is issued.
- Register map (ata_addr):
  - 0x10 data
  - 0x12 sector count
  - 0x13 LBA[7:0]
  - 0x14 LBA[15:8]
  - 0x15 LBA[23:16]
  - 0x16 drive/head
  - 0x17 command (write) / status (read)
- Engine access rule:
  - Assert ata_rd or ata_wr for exactly one cycle, with ata_addr and ata_in stable in that cycle.
  - Hold ata_addr until ata_done.
  - Wait for ata_done, then count RECOVER idle cycles before the next pulse.
  - Never have more than one access outstanding.
- IDLE:
  - cmd_read or cmd_write latches lba and the direction; both asserted together selects read.
  - busy rises the next cycle; err clears.
  - Commands arriving while busy=1 are ignored.
- SETUP: six writes, in order:
  - 0x12 ← 0x0001
  - 0x13 ← lba[7:0]
  - 0x14 ← lba[15:8]
  - 0x15 ← lba[23:16]
  - 0x16 ← {8'h00, 4'hE, lba[27:24]}
  - 0x17 ← 0x0020 (read) or 0x0030 (write)
  - Upper byte of ata_in is zero for all of these.
- POLL_DRQ: read 0x17; status ← ata_out[7:0] in the ata_done cycle. Evaluate in priority order:
  - BSY (bit 7) = 1: re-poll.
  - ERR (bit 0) = 1: go to ERROR.
  - DRQ (bit 3) = 1: go to XFER.
  - Otherwise: re-poll.
- XFER: 256 data-register accesses, buf_addr 0..255 in order.
  - Read direction: in each ata_done cycle, buf_wdata ← ata_out and buf_we = 1 for that single cycle at the current buf_addr.
  - Write direction: buf_addr is driven at least one cycle before each ata_wr pulse; ata_in = buf_rdata.
  - buf_addr increments after each completed access and wraps 255→0 at the end of the phase.
- POLL_END: poll 0x17 until BSY = 0.
  - ERR = 1 goes to ERROR.
  - Otherwise go to DONE.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- ERROR: err = 1, done pulses, busy = 0, return to IDLE.
- Timeout: a 16-bit poll counter resets on entry to each poll phase. When it reaches POLL_LIMIT without exit, go to ERROR; status holds the last value read.
- ata_done arriving with no access outstanding is ignored.

Test Plan:
- Read LBA 0x0123456: check the writes 12←01, 13←56, 14←34, 15←12, 16←E0, 17←20. Status returns 0x80, 0x80, 0x58 → XFER begins after 3 polls. Drive returns words 0x0000..0x00FF → buf_we written at addr n with data n for all 256 words. Final status 0x50 → done pulse, err = 0, status = 0x50.
- Write LBA 0xFFFFFFF with buffer pattern ~n: drive/head write = 0xEF, command = 0x30. 256 ata_wr pulses carry 0xFFFF - n at addr n. Final status 0x50 → done.
- Status 0x51 on the first poll → no data accesses, err = 1, done pulse, status = 0x51.
- Status stuck at 0x80 with POLL_LIMIT = 4 → ERROR after exactly 4 reads.
- Engine pacing: at least RECOVER idle cycles between every ata_done and the next pulse. cmd_read while busy → ignored. cmd_read and cmd_write asserted together → read.
- Reset asserted at word 100 of XFER → ata_rd/ata_wr drop asynchronously, busy = 0, no done. A new command afterwards completes normally.
